// File: rtl/ddr3_fb_pkg.sv
// Shared definitions for the DDR3 framebuffer reader/writer pair: MIG command
// constants, writer FSM states and the common pixel word / address packing.
package ddr3_fb_pkg;

  localparam logic [2:0] MIG_INSTR_READ  = 3'b001;
  localparam logic [2:0] MIG_INSTR_WRITE = 3'b000;
  localparam logic [5:0] MIG_BL8         = 6'h07;

  typedef logic [12:0] seg_key_t;

  typedef struct packed {
    logic [8:0] x;
    logic [6:0] y;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } pixel_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb666_t;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'b001,
    ST_WR_DATA  = 3'b010,
    ST_EMIT_CMD = 3'b100
  } wr_state_e;

  function automatic logic [31:0] pack_rgb666(input logic [5:0] r,
                                              input logic [5:0] g,
                                              input logic [5:0] b);
    return {8'h00, r, 2'b00, g, 2'b00, b, 2'b00};
  endfunction

  function automatic rgb666_t unpack_rgb666(input logic [31:0] word);
    rgb666_t p;
    logic    unused_pad;
    unused_pad = ^{word[31:24], word[17:16], word[9:8], word[1:0]};
    p.r = word[23:18];
    p.g = word[15:10];
    p.b = word[7:2];
    return p;
  endfunction

  function automatic seg_key_t seg_key(input logic [6:0] y, input logic [8:0] x);
    return {y, x[8:3]};
  endfunction

  // One line segment is 8 words of 4 bytes, so the key lands directly at byte bit 5.
  function automatic logic [29:0] pack_byte_addr(input seg_key_t key);
    return {12'h000, key, 3'b000, 2'b00};
  endfunction

endpackage

// File: rtl/ddr3_fb_writer_if.sv
// MIG user-port signals used by the framebuffer writer; master is the writer,
// slave is the MIG (or a model of it).
interface ddr3_fb_writer_if;
  logic        mig_cmd_en;
  logic [2:0]  mig_cmd_instr;
  logic [5:0]  mig_cmd_bl;
  logic [29:0] mig_cmd_byte_addr;
  logic        mig_cmd_empty;
  logic        mig_cmd_full;
  logic        mig_wr_en;
  logic [3:0]  mig_wr_mask;
  logic [31:0] mig_wr_data;
  logic        mig_wr_full;
  logic        mig_wr_empty;
  logic        mig_wr_underrun;
  logic        mig_wr_error;
  logic [6:0]  mig_wr_count;
  logic        mig_rd_en;

  modport master (
    output mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr,
    output mig_wr_en, mig_wr_mask, mig_wr_data, mig_rd_en,
    input  mig_cmd_empty, mig_cmd_full,
    input  mig_wr_full, mig_wr_empty, mig_wr_underrun, mig_wr_error, mig_wr_count
  );

  modport slave (
    input  mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr,
    input  mig_wr_en, mig_wr_mask, mig_wr_data, mig_rd_en,
    output mig_cmd_empty, mig_cmd_full,
    output mig_wr_full, mig_wr_empty, mig_wr_underrun, mig_wr_error, mig_wr_count
  );
endinterface

// File: rtl/ddr3_fb_wr_seg_buf.sv
// Single open line segment: 8 pixel words, their valid mask and the segment key.
// A clear and a write in the same cycle leave only the newly written word valid.
module ddr3_fb_wr_seg_buf
  import ddr3_fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_idx_i,
  input  logic [31:0] wr_word_i,
  input  seg_key_t    wr_key_i,
  input  seg_key_t    cmp_key_i,
  input  logic [2:0]  rd_idx_i,
  output logic [31:0] rd_word_o,
  output logic        rd_valid_o,
  output seg_key_t    key_o,
  output logic [7:0]  valid_o,
  output logic        empty_o,
  output logic        match_o
);

  logic [31:0] words_q [8];
  logic [7:0]  valid_q;
  logic [7:0]  valid_d;
  seg_key_t    key_q;

  always_comb begin
    valid_d = clear_i ? 8'h00 : valid_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 8'h00;
      key_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        words_q[i] <= 32'h0;
      end
    end else begin
      valid_q <= valid_d;
      if (wr_en_i) begin
        key_q             <= wr_key_i;
        words_q[wr_idx_i] <= wr_word_i;
      end
    end
  end

  assign rd_word_o  = words_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign key_o      = key_q;
  assign valid_o    = valid_q;
  assign empty_o    = (valid_q == 8'h00);
  assign match_o    = (key_q == cmp_key_i);

endmodule

// File: rtl/ddr3_fb_writer.sv
// Coalesces (x, y) RGB666 pixel writes into 8-aligned line segments and writes each
// one to DDR3 as a masked burst-of-8 through a MIG user port.
module ddr3_fb_writer
  import ddr3_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mig_ready_i,
  ddr3_fb_writer_if.master  mig,
  input  logic [8:0]        x_i,
  input  logic [6:0]        y_i,
  input  logic [5:0]        r_i,
  input  logic [5:0]        g_i,
  input  logic [5:0]        b_i,
  input  logic              push_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              err_o
);

  wr_state_e   state_q;
  logic [2:0]  idx_q;
  pixel_t      pend_q;
  logic        pend_valid_q;
  logic        flush_pend_q;
  logic        err_q;

  logic        buf_clear;
  logic        buf_wr_en;
  logic [2:0]  buf_wr_idx;
  logic [31:0] buf_wr_word;
  seg_key_t    buf_wr_key;
  logic [31:0] buf_rd_word;
  logic        buf_rd_valid;
  seg_key_t    buf_key;
  logic [7:0]  buf_valid;
  logic        buf_empty;
  logic        buf_match;

  seg_key_t    push_key;
  logic        push_acc;
  logic        flush_acc;
  logic        push_fits;
  logic        push_spill;
  logic [7:0]  valid_after;
  logic        in_wr;
  logic        in_emit;
  logic        word_go;
  logic        cmd_go;
  logic        unused_mig;

  assign push_key    = seg_key(y_i, x_i);
  assign ready_o     = (state_q == ST_COLLECT) && mig_ready_i;
  assign push_acc    = push_i && ready_o;
  assign flush_acc   = flush_i && ready_o;
  assign push_fits   = push_acc && (buf_empty || buf_match);
  assign push_spill  = push_acc && !push_fits;
  assign valid_after = buf_valid | (8'b1 << x_i[2:0]);
  assign in_wr       = (state_q == ST_WR_DATA);
  assign in_emit     = (state_q == ST_EMIT_CMD);
  assign word_go     = in_wr && !mig.mig_wr_full;
  assign cmd_go      = in_emit && !mig.mig_cmd_full;
  assign buf_clear   = cmd_go;

  // The pending pixel reuses the buffer write port as the old segment is retired.
  always_comb begin
    buf_wr_en   = push_fits;
    buf_wr_idx  = x_i[2:0];
    buf_wr_word = pack_rgb666(r_i, g_i, b_i);
    buf_wr_key  = push_key;
    if (cmd_go && pend_valid_q) begin
      buf_wr_en   = 1'b1;
      buf_wr_idx  = pend_q.x[2:0];
      buf_wr_word = pack_rgb666(pend_q.r, pend_q.g, pend_q.b);
      buf_wr_key  = seg_key(pend_q.y, pend_q.x);
    end
  end

  ddr3_fb_wr_seg_buf u_seg_buf (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (buf_clear),
    .wr_en_i    (buf_wr_en),
    .wr_idx_i   (buf_wr_idx),
    .wr_word_i  (buf_wr_word),
    .wr_key_i   (buf_wr_key),
    .cmp_key_i  (push_key),
    .rd_idx_i   (idx_q),
    .rd_word_o  (buf_rd_word),
    .rd_valid_o (buf_rd_valid),
    .key_o      (buf_key),
    .valid_o    (buf_valid),
    .empty_o    (buf_empty),
    .match_o    (buf_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      idx_q        <= 3'd0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (mig.mig_wr_underrun || mig.mig_wr_error) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_COLLECT: begin
          if (push_spill) begin
            pend_q       <= '{x: x_i, y: y_i, r: r_i, g: g_i, b: b_i};
            pend_valid_q <= 1'b1;
            flush_pend_q <= flush_i;
            state_q      <= ST_WR_DATA;
          end else if ((push_fits && valid_after == 8'hFF) ||
                       (flush_acc && (push_fits || !buf_empty))) begin
            state_q <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (word_go) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= ST_EMIT_CMD;
            end
          end
        end
        ST_EMIT_CMD: begin
          if (cmd_go) begin
            pend_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            state_q      <= (pend_valid_q && flush_pend_q) ? ST_WR_DATA : ST_COLLECT;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign mig.mig_cmd_en        = cmd_go;
  assign mig.mig_cmd_instr     = MIG_INSTR_WRITE;
  assign mig.mig_cmd_bl        = MIG_BL8;
  assign mig.mig_cmd_byte_addr = in_emit ? pack_byte_addr(buf_key) : 30'h0;
  assign mig.mig_wr_en         = word_go;
  assign mig.mig_wr_data       = in_wr ? buf_rd_word : 32'h0;
  assign mig.mig_wr_mask       = (in_wr && !buf_rd_valid) ? 4'hF : 4'h0;
  assign mig.mig_rd_en         = 1'b0;

  assign busy_o = !buf_empty || pend_valid_q || (state_q != ST_COLLECT);
  assign err_o  = err_q;

  assign unused_mig = ^{mig.mig_cmd_empty, mig.mig_wr_empty, mig.mig_wr_count};

endmodule
